// File: rtl/col_merge_pkg.sv
// Shared types and helpers for the col_merge_arb capture-and-merge stage.
package col_merge_pkg;

    localparam int unsigned OVF_CNT_W  = 16;
    localparam int unsigned COL_W_MAX  = 4;   // enough for COLS up to 16
    localparam int unsigned DATA_W_MAX = 32;

    // Column/data pair held in the output register; users slice to their widths.
    typedef struct packed {
        logic [COL_W_MAX-1:0]  col;
        logic [DATA_W_MAX-1:0] data;
    } col_word_t;

    // Never returns 0, so a column index is always at least one bit wide.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/col_fifo.sv
// Single-column synchronous FIFO. A push while full is dropped and flagged on drop,
// even when a pop happens in the same cycle.
module col_fifo #(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic              drop
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en, rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign drop  = push & full;
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/col_merge_arb.sv
// Per-column FIFO capture merged round-robin onto one valid/ready stream (DATA_W up to 32).
// Define COL_MERGE_OVF_CNT_EN to add saturating per-column drop counters on ovf_cnt.
module col_merge_arb
    import col_merge_pkg::*;
#(
    parameter int unsigned COLS   = 4,
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rstb,
    input  logic [COLS-1:0]                   ival,
    input  logic [COLS-1:0][DATA_W-1:0]       idata,
    output logic                              ovalid,
    output logic [DATA_W-1:0]                 odata,
    output logic [clog2_min1(COLS)-1:0]       ocol,
    input  logic                              oready,
    output logic [COLS-1:0]                   ofull,
    output logic [COLS-1:0]                   ovf,
    input  logic                              ovf_clr
`ifdef COL_MERGE_OVF_CNT_EN
    ,
    output logic [COLS-1:0][OVF_CNT_W-1:0]    ovf_cnt
`endif
);

    localparam int unsigned CW = clog2_min1(COLS);

    logic [COLS-1:0]   fifo_empty, fifo_full, fifo_drop, fifo_pop;
    logic [DATA_W-1:0] fifo_rdata [COLS];

    for (genvar c = 0; c < COLS; c++) begin : g_col
        col_fifo #(
            .DATA_W(DATA_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rstb (rstb),
            .push (ival[c]),
            .pop  (fifo_pop[c]),
            .wdata(idata[c]),
            .rdata(fifo_rdata[c]),
            .empty(fifo_empty[c]),
            .full (fifo_full[c]),
            .drop (fifo_drop[c])
        );
    end

    logic              load, gnt_found;
    logic [CW-1:0]     gnt_idx, scan_idx;
    logic [DATA_W-1:0] gnt_data;
    int unsigned       scan;
    logic [CW-1:0]     last_grant_q, last_grant_d;
    col_word_t         out_q, out_d;
    logic              ovalid_q, ovalid_d;

    // Round-robin scan starting just after the last granted column.
    always_comb begin
        load      = ~ovalid_q | oready;
        gnt_found = 1'b0;
        gnt_idx   = last_grant_q;
        scan      = 0;
        scan_idx  = '0;
        for (int unsigned i = 1; i <= COLS; i++) begin
            scan = 32'(last_grant_q) + i;
            if (scan >= COLS) begin
                scan = scan - COLS;
            end
            scan_idx = CW'(scan);
            if (!gnt_found && !fifo_empty[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
        gnt_data = fifo_rdata[gnt_idx];
    end

    always_comb begin
        fifo_pop     = '0;
        out_d        = out_q;
        ovalid_d     = ovalid_q;
        last_grant_d = last_grant_q;
        if (load) begin
            ovalid_d = gnt_found;
            if (gnt_found) begin
                fifo_pop[gnt_idx] = 1'b1;
                out_d             = '0;
                out_d.col         = COL_W_MAX'(gnt_idx);
                out_d.data        = DATA_W_MAX'(gnt_data);
                last_grant_d      = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_q        <= '0;
            ovalid_q     <= 1'b0;
            last_grant_q <= CW'(COLS - 1);
        end else begin
            out_q        <= out_d;
            ovalid_q     <= ovalid_d;
            last_grant_q <= last_grant_d;
        end
    end

    logic unused_out_bits;
    assign unused_out_bits = ^out_q;

    assign ovalid = ovalid_q;
    assign odata  = out_q.data[DATA_W-1:0];
    assign ocol   = out_q.col[CW-1:0];
    assign ofull  = fifo_full;

    // A clear wins over a drop in the same cycle.
    logic [COLS-1:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_clr ? '0 : (ovf_q | fifo_drop);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

`ifdef COL_MERGE_OVF_CNT_EN
    logic [COLS-1:0][OVF_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (ovf_clr) begin
                cnt_d[c] = '0;
            end else if (fifo_drop[c] && (cnt_q[c] != '1)) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovf_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_col_merge_arb.sv
// Self-checking bench for col_merge_arb: vector table plus hand-written stall, overflow,
// alternation and reset sequences, with a scoreboard checking every output transfer.
module tb_col_merge_arb;

    localparam int unsigned COLS   = 4;
    localparam int unsigned DATA_W = 2;
    localparam int unsigned DEPTH  = 4;

    logic                        clk;
    logic                        rstb;
    logic [COLS-1:0]             ival;
    logic [COLS-1:0][DATA_W-1:0] idata;
    logic                        ovalid;
    logic [DATA_W-1:0]           odata;
    logic [1:0]                  ocol;
    logic                        oready;
    logic [COLS-1:0]             ofull;
    logic [COLS-1:0]             ovf;
    logic                        ovf_clr;
`ifdef COL_MERGE_OVF_CNT_EN
    logic [COLS-1:0][15:0]       ovf_cnt;
`endif

    col_merge_arb #(
        .COLS  (COLS),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rstb   (rstb),
        .ival   (ival),
        .idata  (idata),
        .ovalid (ovalid),
        .odata  (odata),
        .ocol   (ocol),
        .oready (oready),
        .ofull  (ofull),
        .ovf    (ovf),
        .ovf_clr(ovf_clr)
`ifdef COL_MERGE_OVF_CNT_EN
        ,
        .ovf_cnt(ovf_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [3:0] sb[$];   // expected {col, data}, in output order

    typedef struct {
        logic [3:0]  ival;
        logic [7:0]  idata;
        int          n;
        logic [15:0] exp;   // nibble j = j-th expected {col, data}
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [7:0] d);
        ival  = v;
        idata = d;
    endtask

    task automatic expect_word(input logic [3:0] e);
        sb.push_back(e);
    endtask

    task automatic wait_drain(output int w);
        w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        rstb    = 1'b0;
        ival    = '0;
        idata   = '0;
        oready  = 1'b1;
        ovf_clr = 1'b0;
        sb.delete();
        @(negedge clk);
        #1;
        rstb = 1'b1;
        step();
    endtask

    // Output monitor: scoreboard pop on each transfer, and hold check while stalled.
    initial begin
        logic       stall;
        logic [4:0] prev;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (!rstb) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_stable", {ovalid, ocol, odata}, prev);
                end
                if (ovalid && oready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_out: got col %0d data %0d, required no transfer",
                                 ocol, odata);
                    end else begin
                        logic [3:0] e;
                        e = sb.pop_front();
                        check("out_word", {ocol, odata}, e);
                    end
                end
                stall = ovalid && !oready;
                prev  = {ovalid, ocol, odata};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        logic [7:0] d;

        tbl[0] = '{4'hF, 8'hE4, 4, 16'hFA50};
        tbl[1] = '{4'hA, 8'h48, 2, 16'h00D6};
        tbl[2] = '{4'h5, 8'h03, 2, 16'h0083};
        tbl[3] = '{4'h9, 8'h81, 2, 16'h001E};
        tbl[4] = '{4'h6, 8'h10, 2, 16'h0094};
        tbl[5] = '{4'hF, 8'h1B, 4, 16'h963C};
        tbl[6] = '{4'h1, 8'h02, 1, 16'h0002};

        rstb    = 1'b0;
        ival    = '0;
        idata   = '0;
        oready  = 1'b1;
        ovf_clr = 1'b0;
        #3;
        check("rst_ovalid", ovalid, 0);
        check("rst_odata", odata, 0);
        check("rst_ocol", ocol, 0);
        check("rst_ofull", ofull, 0);
        check("rst_ovf", ovf, 0);
`ifdef COL_MERGE_OVF_CNT_EN
        check("rst_ovf_cnt", ovf_cnt, 0);
`endif
        @(negedge clk);
        #1;
        rstb = 1'b1;
        step();

        // Minimum latency: single pulse on column 2.
        check("idle_ovalid", ovalid, 0);
        drive(4'b0100, 8'h30);
        expect_word({2'd2, 2'd3});
        step();
        drive(4'b0000, 8'h00);
        check("lat_n1_ovalid", ovalid, 0);
        step();
        check("lat_n2_ovalid", ovalid, 1);
        check("lat_n2_ocol", ocol, 2);
        check("lat_n2_odata", odata, 3);
        step();
        check("lat_one_cycle", ovalid, 0);
        wait_drain(w);

        // Table: one input cycle per vector, expected order and drain time.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].ival, tbl[i].idata);
            for (int j = 0; j < tbl[i].n; j++) begin
                expect_word(tbl[i].exp[4*j +: 4]);
            end
            step();
            drive(4'b0000, 8'h00);
            wait_drain(w);
            check("vec_drain_cycles", w, tbl[i].n + 1);
            step();
            check("vec_idle_after", ovalid, 0);
        end

        // Stall: column 0 occupies the output register, column 1 fills and overflows.
        do_reset();
        oready = 1'b0;
        drive(4'b0011, 8'h02);
        expect_word({2'd0, 2'd2});
        expect_word({2'd1, 2'd0});
        step();
        check("stall_ofull_k0", ofull, 4'b0000);
        for (int k = 1; k < 6; k++) begin
            d = '0;
            d[3:2] = 2'(k);
            drive(4'b0010, d);
            if (k <= 3) expect_word({2'd1, 2'(k)});
            step();
            check("stall_ofull", ofull, (k >= 3) ? 4'b0010 : 4'b0000);
            check("stall_ovf", ovf, (k >= 4) ? 4'b0010 : 4'b0000);
            check("stall_out", {ovalid, ocol, odata}, {1'b1, 2'd0, 2'd2});
        end
        drive(4'b0000, 8'h00);
        step();
        step();
        oready = 1'b1;
        wait_drain(w);
        step();
        check("stall_ofull_after", ofull, 0);
        check("stall_ovf_sticky", ovf, 4'b0010);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("stall_ovf_cleared", ovf, 0);

        // Columns 0 and 3 continuously valid: strict alternation at full rate.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            d = '0;
            d[1:0] = 2'(k);
            d[7:6] = 2'(k + 1);
            drive(4'b1001, d);
            expect_word({2'd0, 2'(k)});
            expect_word({2'd3, 2'(k + 1)});
            step();
        end
        drive(4'b0000, 8'h00);
        wait_drain(w);
        check("alt_drain_cycles", w, 8);
        check("alt_no_ovf", ovf, 0);

        // Overflow: 25 pushes on column 0 with oready low gives 20 drops.
        do_reset();
        oready = 1'b0;
        for (int k = 0; k < 25; k++) begin
            d = '0;
            d[1:0] = 2'(k);
            drive(4'b0001, d);
            if (k < 5) expect_word({2'd0, 2'(k)});
            step();
        end
        check("ovf_flag", ovf, 4'b0001);
        check("ovf_ofull", ofull, 4'b0001);
`ifdef COL_MERGE_OVF_CNT_EN
        check("ovf_cnt0", ovf_cnt[0], 20);
        check("ovf_cnt1", ovf_cnt[1], 0);
`endif
        drive(4'b0001, 8'h00);
        ovf_clr = 1'b1;
        step();
        drive(4'b0000, 8'h00);
        ovf_clr = 1'b0;
        check("clr_same_cycle_ovf", ovf, 0);
`ifdef COL_MERGE_OVF_CNT_EN
        check("clr_same_cycle_cnt", ovf_cnt[0], 0);
`endif
        step();
        check("clr_stays_clear", ovf, 0);
        oready = 1'b1;
        wait_drain(w);

        // Asynchronous reset with data presented and buffered.
        do_reset();
        oready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(4'b0111, 8'h39);
            step();
        end
        drive(4'b0000, 8'h00);
        check("pre_rst_ovalid", ovalid, 1);
        #2;
        rstb = 1'b0;
        #1;
        check("async_rst_ovalid", ovalid, 0);
        check("async_rst_ofull", ofull, 0);
        sb.delete();
        @(negedge clk);
        #1;
        rstb   = 1'b1;
        oready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("no_stale_out", ovalid, 0);
        end
        drive(4'b1000, 8'h40);
        expect_word({2'd3, 2'd1});
        step();
        drive(4'b0000, 8'h00);
        wait_drain(w);
        step();
        check("post_rst_idle", ovalid, 0);

        check("sb_empty_end", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
